// File: rtl/aes_key_expander_if.sv
// rtl/aes_key_expander_if.sv - valid/ready handshake interface carrying the cipher key
interface dvr_if #(
    parameter int WIDTH = 128
) ();
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             rdy;

    modport slave  (input data, input valid, output rdy);
    modport master (output data, output valid, input rdy);
endinterface

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - AES-128 key schedule, one round key per clock, registered round key read port
// Optional idx_err output is enabled by defining AES_KEY_EXPANDER_IDX_ERR_EN.

module aes_key_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];
endmodule

module aes_key_expander #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int NUM_ROUNDS          = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    dvr_if.slave                             key_in,
    input  logic [3:0]                       round_idx,
    output logic [DATA_WIDTH_IN_BYTES*8-1:0] round_key,
    output logic                             keys_valid,
    output logic                             busy
`ifdef AES_KEY_EXPANDER_IDX_ERR_EN
    ,
    output logic                             idx_err
`endif
);
    localparam int KEY_W = DATA_WIDTH_IN_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [KEY_W-1:0] rk [NUM_ROUNDS+1];
    logic [KEY_W-1:0] prev_key;
    logic [KEY_W-1:0] next_key;
    logic [KEY_W-1:0] read_key;
    logic [31:0]      rot_word;
    logic [31:0]      sub_word;
    logic [31:0]      temp_word;
    logic [31:0]      w0, w1, w2, w3;
    logic [7:0]       rcon;
    logic             accept;

    assign key_in.rdy = (state != EXPAND);
    assign accept     = key_in.valid && key_in.rdy;

    // cnt points at the key being produced, so the source is rk[cnt-1]
    always_comb begin
        prev_key = '0;
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            if (cnt == 4'(i + 1)) prev_key = rk[i];
        end
    end

    assign rot_word = {prev_key[23:0], prev_key[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_key_sbox u_sbox (
            .a (rot_word[8*g +: 8]),
            .y (sub_word[8*g +: 8])
        );
    end

    always_comb begin
        case (cnt)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign temp_word = sub_word ^ {rcon, 24'h000000};
    assign w0        = prev_key[127:96] ^ temp_word;
    assign w1        = prev_key[95:64]  ^ w0;
    assign w2        = prev_key[63:32]  ^ w1;
    assign w3        = prev_key[31:0]   ^ w2;
    assign next_key  = {w0, w1, w2, w3};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            keys_valid <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
        end else begin
            case (state)
                IDLE, READY: begin
                    if (accept) begin
                        rk[0]      <= key_in.data;
                        cnt        <= 4'd1;
                        keys_valid <= 1'b0;
                        busy       <= 1'b1;
                        state      <= EXPAND;
                    end
                end
                EXPAND: begin
                    for (int i = 1; i <= NUM_ROUNDS; i++) begin
                        if (cnt == 4'(i)) rk[i] <= next_key;
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(NUM_ROUNDS)) begin
                        keys_valid <= 1'b1;
                        busy       <= 1'b0;
                        state      <= READY;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Out-of-range indices fall through to zero
    always_comb begin
        read_key = '0;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (round_idx == 4'(i)) read_key = rk[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            round_key <= '0;
        end else begin
            round_key <= read_key;
        end
    end

`ifdef AES_KEY_EXPANDER_IDX_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_err <= 1'b0;
        end else begin
            idx_err <= (round_idx > 4'(NUM_ROUNDS)) || !keys_valid;
        end
    end
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - directed self-checking bench for aes_key_expander
module tb_aes_key_expander;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   round_idx;
    logic [127:0] round_key;
    logic         keys_valid;
    logic         busy;
`ifdef AES_KEY_EXPANDER_IDX_ERR_EN
    logic         idx_err;
`endif

    int checks = 0;
    int errors = 0;
    int cycles;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic [127:0] fips_rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    dvr_if #(.WIDTH(128)) key_if ();

    aes_key_expander dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_if),
        .round_idx  (round_idx),
        .round_key  (round_key),
        .keys_valid (keys_valid),
`ifdef AES_KEY_EXPANDER_IDX_ERR_EN
        .idx_err    (idx_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_err(input string tag, input logic exp);
`ifdef AES_KEY_EXPANDER_IDX_ERR_EN
        chk($sformatf("%s idx_err", tag), 128'(idx_err), 128'(exp));
`endif
    endtask

    task automatic read_idx(input logic [3:0] idx, input logic [127:0] exp, input logic err, input string tag);
        round_idx = idx;
        @(negedge clk);
        chk(tag, round_key, exp);
        chk_err(tag, err);
    endtask

    task automatic wait_valid(input string tag);
        cycles = 0;
        while (!keys_valid && cycles < 30) begin
            @(negedge clk);
            cycles++;
        end
        chk($sformatf("%s latency", tag), 128'(cycles), 128'd10);
    endtask

    task automatic send_key(input logic [127:0] k, input string tag);
        key_if.data  = k;
        key_if.valid = 1'b1;
        @(negedge clk);
        chk($sformatf("%s busy", tag), 128'(busy), 128'd1);
        chk($sformatf("%s rdy", tag), 128'(key_if.rdy), 128'd0);
        chk($sformatf("%s keys_valid low", tag), 128'(keys_valid), 128'd0);
        key_if.valid = 1'b0;
        wait_valid(tag);
    endtask

    initial begin
        rst          = 1'b0;
        key_if.valid = 1'b0;
        key_if.data  = '0;
        round_idx    = 4'd0;

        #12;
        chk("reset round_key", round_key, 128'd0);
        chk("reset keys_valid", 128'(keys_valid), 128'd0);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset rdy", 128'(key_if.rdy), 128'd1);
        chk_err("reset", 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle rdy", 128'(key_if.rdy), 128'd1);
        chk("idle busy", 128'(busy), 128'd0);

        send_key(FIPS_KEY, "fips");
        chk("fips busy done", 128'(busy), 128'd0);
        for (int i = 0; i <= 10; i++) begin
            read_idx(4'(i), fips_rk[i], 1'b0, $sformatf("fips rk%0d", i));
        end
        read_idx(4'd11, 128'd0, 1'b1, "idx11");
        read_idx(4'd15, 128'd0, 1'b1, "idx15");
        read_idx(4'd10, fips_rk[10], 1'b0, "fips rk10 again");

        send_key(128'd0, "zero");
        read_idx(4'd1, ZERO_RK1, 1'b0, "zero rk1");
        read_idx(4'd10, ZERO_RK10, 1'b0, "zero rk10");

        // second key held on valid while the first is still expanding
        key_if.data  = FIPS_KEY;
        key_if.valid = 1'b1;
        round_idx    = 4'd1;
        @(negedge clk);
        chk("held first busy", 128'(busy), 128'd1);
        key_if.data = 128'd0;
        repeat (3) @(negedge clk);
        chk("read during expand", round_key, fips_rk[1]);
        chk("held rdy low", 128'(key_if.rdy), 128'd0);
        cycles = 3;
        while (!key_if.rdy && cycles < 30) begin
            @(negedge clk);
            cycles++;
        end
        chk("held rdy return", 128'(cycles), 128'd10);
        chk("held ready keys_valid", 128'(keys_valid), 128'd1);
        @(negedge clk);
        chk("held accept keys_valid", 128'(keys_valid), 128'd0);
        chk("held accept busy", 128'(busy), 128'd1);
        key_if.valid = 1'b0;
        wait_valid("held");
        read_idx(4'd10, ZERO_RK10, 1'b0, "held rk10");
        read_idx(4'd1, ZERO_RK1, 1'b0, "held rk1");

        // reset in the middle of an expansion
        key_if.data  = FIPS_KEY;
        key_if.valid = 1'b1;
        round_idx    = 4'd10;
        @(negedge clk);
        key_if.valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort keys_valid", 128'(keys_valid), 128'd0);
        chk("abort round_key", round_key, 128'd0);
        chk("abort busy", 128'(busy), 128'd0);
        chk("abort rdy", 128'(key_if.rdy), 128'd1);
        chk_err("abort", 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post abort keys_valid", 128'(keys_valid), 128'd0);
        chk("post abort rk10", round_key, 128'd0);
        chk_err("post abort", 1'b1);
        send_key(128'd0, "fresh");
        read_idx(4'd1, ZERO_RK1, 1'b0, "fresh rk1");
        read_idx(4'd10, ZERO_RK10, 1'b0, "fresh rk10");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_key_expander.md
AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

Interface
REQ-001 Parameter DATA_WIDTH_IN_BYTES, default 16, block/key width in bytes; only 16 (AES-128) SHALL be supported.
REQ-002 Parameter NUM_ROUNDS, default 10, number of round keys after round key 0; only 10 SHALL be supported.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserting it (0) SHALL reset immediately, and deassertion SHALL take effect at the next clk edge.
REQ-005 key_in  dvr_if.slave  data 128 / valid 1 / rdy 1  cipher key; data[127:120] is FIPS-197 key byte 0.
REQ-006 round_idx  input  4  round key select, 0..10.
REQ-007 round_key  output  128  selected round key; byte 0 in [127:120].
REQ-008 keys_valid  output  1  high when all 11 round keys are valid for the current key.
REQ-009 busy  output  1  high while expansion is in progress.

Function
REQ-010 The block SHALL use three states: IDLE, EXPAND and READY.
REQ-011 key_in.rdy SHALL be 1 in IDLE and READY, and 0 in EXPAND.
REQ-012 When key_in.valid and key_in.rdy are both high at edge E0, the block SHALL store key_in.data as rk[0], set the round counter to 1, clear keys_valid and enter EXPAND.
REQ-013 In EXPAND, each edge SHALL compute rk[cnt] from rk[cnt-1] per FIPS-197 (RotWord, SubWord, Rcon[cnt] XOR, then 4-word chain) and increment cnt.
REQ-014 Rcon SHALL be the sequence 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10.
REQ-015 Each round SHALL use 4 S-box instances and no multi-cycle rounds.
REQ-016 On the edge that writes rk[10] (E10), the block SHALL enter READY; keys_valid SHALL be 1 from that edge, i.e. 10 cycles after acceptance.
REQ-017 busy SHALL be 1 exactly while the state is EXPAND.
REQ-018 In READY, a new key_in handshake SHALL behave as REQ-012: keys_valid drops on the same edge and the old keys SHALL be considered invalid.
REQ-019 key_in.valid while rdy is 0 SHALL be ignored and not latched; the upstream holds it until rdy returns.
REQ-020 round_key SHALL be registered: round_key = rk[round_idx] sampled at edge N and presented after edge N (1-cycle read latency).
REQ-021 round_key SHALL be driven in every state; its contents are meaningful only when keys_valid is 1.
REQ-022 round_idx greater than 10 SHALL yield round_key = 0.
REQ-023 Reading during EXPAND SHALL return the current register contents; already-computed rounds SHALL read correctly.

Reset
REQ-024 When rst=0, the block SHALL set state=IDLE, cnt=0, all rk registers to 0, round_key=0, keys_valid=0 and busy=0; key_in.rdy SHALL become 1 once rst=1.
REQ-025 A reset asserted mid-EXPAND SHALL abort the expansion; no partial keys SHALL be reported valid afterwards.

Configuration
REQ-026 With macro AES_KEY_EXPANDER_IDX_ERR_EN defined, the block SHALL add output idx_err (1 bit, registered, reset 0), which pulses 1 for one cycle, aligned with round_key, for each sampled round_idx greater than 10, or any sampled round_idx while keys_valid=0.
REQ-027 Without AES_KEY_EXPANDER_IDX_ERR_EN, the idx_err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Key 2b7e151628aed2a6abf7158809cf4f3c -> keys_valid rises 10 cycles after the handshake; idx 1 reads a0fafe1788542cb123a339392a6c7605; idx 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-029 All-zero key -> idx 1 reads 62636363626363636263636362636363; idx 10 reads b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-030 Second key sent while busy (valid held high) -> no acceptance until READY, then it is accepted on the first rdy cycle; keys_valid drops for 10 cycles, then the new rk[10] is correct.
REQ-031 rst pulsed low at cycle 5 of EXPAND -> keys_valid=0, round_key=0, state IDLE, rdy=1; a fresh key then expands correctly.
REQ-032 round_idx=11 and round_idx=15 -> round_key=0 one cycle later; with AES_KEY_EXPANDER_IDX_ERR_EN defined, idx_err=1 on those cycles and 0 for idx 0..10 with keys_valid=1.
REQ-033 round_idx stepped 0..10 on consecutive cycles in READY -> round_key follows with 1-cycle lag and matches the FIPS-197 Appendix A schedule.
